// File: rtl/controle_entrada_saida.sv
// I/O controller: debounced confirm button, input-capture handshake that stalls the PC,
// and a latched 32-bit display register for output instructions.
module controle_entrada_saida #(
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned LARGURA_SW = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            opcode,
  input  logic                  botao,
  input  logic [LARGURA_SW-1:0] switches,
  input  logic [31:0]           regDado,
  output logic                  pcHold,
  output logic [31:0]           dadoEntrada,
  output logic                  escritaEntrada,
  output logic [31:0]           display,
  output logic                  displayValido,
  output logic [2:0]            estado
);

  localparam logic [4:0] OP_ENTRADA = 5'd19;
  localparam logic [4:0] OP_SAIDA   = 5'd20;
  localparam logic [7:0] CNT_LIMITE = 8'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ESPERA    = 3'd1,
    CAPTURA   = 3'd2,
    LIBERA    = 3'd3,
    CONCLUIDO = 3'd4
  } estadoT;

  estadoT     estadoAtual, proxEstado;
  logic       sync1, sync2;
  logic       botaoDeb;
  logic [7:0] contDeb;
  logic       armado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= botao;
      sync2 <= sync1;
    end
  end

  // The debounced level toggles only after the synchronized level has disagreed for DEBOUNCE cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botaoDeb <= 1'b0;
      contDeb  <= '0;
    end else if (sync2 != botaoDeb) begin
      if (contDeb == CNT_LIMITE) begin
        botaoDeb <= ~botaoDeb;
        contDeb  <= '0;
      end else begin
        contDeb <= contDeb + 8'd1;
      end
    end else begin
      contDeb <= '0;
    end
  end

  // Armed once the button is seen released in ESPERA, so a press held from before never captures.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armado <= 1'b0;
    end else if (estadoAtual == ESPERA) begin
      armado <= armado | ~botaoDeb;
    end else begin
      armado <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estadoAtual <= OCIOSO;
    end else begin
      estadoAtual <= proxEstado;
    end
  end

  always_comb begin
    proxEstado = estadoAtual;
    unique case (estadoAtual)
      OCIOSO:    if (opcode == OP_ENTRADA) proxEstado = ESPERA;
      ESPERA:    if (botaoDeb && armado) proxEstado = CAPTURA;
      CAPTURA:   proxEstado = LIBERA;
      LIBERA:    if (!botaoDeb) proxEstado = CONCLUIDO;
      CONCLUIDO: proxEstado = OCIOSO;
      default:   proxEstado = OCIOSO;
    endcase
  end

  always_comb begin
    pcHold         = 1'b0;
    escritaEntrada = 1'b0;
    estado         = estadoAtual;
    if (!reset) begin
      unique case (estadoAtual)
        OCIOSO:                  pcHold = (opcode == OP_ENTRADA);
        ESPERA, CAPTURA, LIBERA: pcHold = 1'b1;
        default:                 pcHold = 1'b0;
      endcase
    end
    escritaEntrada = (estadoAtual == CAPTURA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dadoEntrada <= '0;
    end else if (estadoAtual == ESPERA && proxEstado == CAPTURA) begin
      dadoEntrada <= 32'(switches);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      display       <= '0;
      displayValido <= 1'b0;
    end else if (opcode == OP_SAIDA &&
                 (estadoAtual == OCIOSO || estadoAtual == CONCLUIDO)) begin
      display       <= regDado;
      displayValido <= 1'b1;
    end
  end

endmodule

// File: doc/controle_entrada_saida.md
CONTROLE_ENTRADA_SAIDA -- requirements
Module: controle_entrada_saida

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4: cycles the synchronized button level must differ from the debounced level before the debounced level toggles (range 2..255).
REQ-002 SHALL have parameter LARGURA_SW, default 16: switch bus width, zero-extended to 32 bits.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port opcode, input, 5: opcode of the current instruction; 19 = input, 20 = output.
REQ-006 SHALL have port botao, input, 1: raw confirm pushbutton, active-high, asynchronous to clock.
REQ-007 SHALL have port switches, input, LARGURA_SW: user data switches.
REQ-008 SHALL have port regDado, input, 32: register-bank value for an output instruction.
REQ-009 SHALL have port pcHold, output, 1: stalls the PC while high.
REQ-010 SHALL have port dadoEntrada, output, 32: captured switch value, zero-extended.
REQ-011 SHALL have port escritaEntrada, output, 1: one-cycle register-bank write-enable pulse for input data.
REQ-012 SHALL have port display, output, 32: latched output value.
REQ-013 SHALL have port displayValido, output, 1: display holds a value written since reset.
REQ-014 SHALL have port estado, output, 3: FSM state code, for debug.

Function
REQ-015 SHALL pass botao through a 2-flop synchronizer; only the second flop output feeds the debouncer.
REQ-016 Debouncer: an 8-bit counter SHALL increment each cycle the synchronized level differs from the debounced level and clear when they are equal.
REQ-017 Debouncer: when the counter equals DEBOUNCE-1 and the levels still differ, the debounced level SHALL toggle on that edge and the counter SHALL clear.
REQ-018 Latency: a clean press SHALL raise the debounced level 2+DEBOUNCE edges after botao rises; glitches shorter than DEBOUNCE cycles SHALL be ignored.
REQ-019 FSM states and codes SHALL be OCIOSO=0, ESPERA=1, CAPTURA=2, LIBERA=3, CONCLUIDO=4.
REQ-020 OCIOSO, opcode==19: next state SHALL be ESPERA; otherwise remain in OCIOSO.
REQ-021 ESPERA, debounced level high: next state SHALL be CAPTURA; otherwise remain in ESPERA.
REQ-022 CAPTURA: next state SHALL be LIBERA unconditionally.
REQ-023 LIBERA, debounced level low: next state SHALL be CONCLUIDO; otherwise remain in LIBERA.
REQ-024 CONCLUIDO: next state SHALL be OCIOSO unconditionally.
REQ-025 pcHold SHALL be combinational: high in ESPERA, CAPTURA and LIBERA, high in OCIOSO when opcode==19, and low in CONCLUIDO regardless of opcode.
REQ-026 On the edge entering CAPTURA, dadoEntrada SHALL load {zeros, switches}; it SHALL hold that value until the next capture.
REQ-027 escritaEntrada SHALL be high for exactly the one cycle spent in CAPTURA.
REQ-028 Entering ESPERA while the debounced level is already high SHALL NOT capture; the user must release and press again (stay in ESPERA until a low-to-high transition).
REQ-029 The button SHALL be edge-qualified by a registered "armed" flag, set when the debounced level is low in ESPERA.
REQ-030 opcode==20 in OCIOSO or CONCLUIDO SHALL load display<=regDado and set displayValido=1 on the next edge, with no stall.
REQ-031 opcode==20 in any other state SHALL be ignored.
REQ-032 displayValido SHALL stay high until reset.
REQ-033 opcode changes while in ESPERA, CAPTURA, LIBERA or CONCLUIDO SHALL NOT alter the FSM sequence.

Reset
REQ-034 reset high SHALL immediately, without waiting for a clock edge, force: state=OCIOSO, synchronizer flops=0, debounced level=0, counter=0, armed=0, dadoEntrada=0, escritaEntrada=0, display=0, displayValido=0.
REQ-035 pcHold SHALL be forced low while reset is high.
REQ-036 reset asserted mid-operation (any state) SHALL abort the sequence with no escritaEntrada pulse.
REQ-037 After reset releases, the FSM SHALL resume from OCIOSO on the next edge.

Verification
REQ-038 Scenario 1: DEBOUNCE=4, opcode=19, switches=16'hA5A5, botao high 10 cycles then low -> pcHold high from cycle 0; escritaEntrada single pulse ≈7 edges after press; dadoEntrada=32'h0000A5A5; pcHold low exactly in CONCLUIDO.
REQ-039 Scenario 2: botao 2-cycle glitch while in ESPERA -> no state change, no escritaEntrada, pcHold stays high.
REQ-040 Scenario 3: botao held high before opcode=19 arrives -> no capture until release and re-press; exactly one escritaEntrada pulse.
REQ-041 Scenario 4: opcode=20, regDado=32'hDEADBEEF in OCIOSO -> next edge display=32'hDEADBEEF, displayValido=1, pcHold=0 throughout.
REQ-042 Scenario 5: reset asserted asynchronously in LIBERA -> estado=0, pcHold=0, display=0, displayValido=0 before the next clock edge.
REQ-043 Scenario 6: opcode held at 19 through CONCLUIDO -> exactly one capture; the FSM re-enters ESPERA only after passing through OCIOSO.
